axi_ram_reader: RTL and testbench

AXI_RAM_READER -- requirements
Module: axi_ram_reader

---
 rtl/axi_ram_reader_if.sv | 34 +++
 rtl/axi_ram_reader.sv | 99 +++++++++
 tb/tb_axi_ram_reader.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/axi_ram_reader_if.sv
// Request and AXI-Stream signals of the RAM burst reader.
// m_axis_tlast exists only when AXI_RAM_TLAST_EN is defined.
interface axi_ram_reader_if #(
    parameter int AW = 8
);
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [7:0]    req_len;
    logic [31:0]   m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
`ifdef AXI_RAM_TLAST_EN
    logic          m_axis_tlast;
`endif

    // master: the reader block (accepts requests, drives the stream)
    modport master (
        input  req_valid, req_addr, req_len, m_axis_tready,
        output req_ready, m_axis_tdata, m_axis_tvalid
`ifdef AXI_RAM_TLAST_EN
        , output m_axis_tlast
`endif
    );

    // slave: requester and stream consumer
    modport slave (
        output req_valid, req_addr, req_len, m_axis_tready,
        input  req_ready, m_axis_tdata, m_axis_tvalid
`ifdef AXI_RAM_TLAST_EN
        , input m_axis_tlast
`endif
    );
endinterface

// File: rtl/axi_ram_reader.sv
// Byte-wide RAM with a write port, streamed out as little-endian 32-bit beats per burst request.
// Optional AXI_RAM_TLAST_EN adds m_axis_tlast on the final beat.
module axi_ram_reader #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [7:0]           wr_data,
    axi_ram_reader_if.master     bus,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

    logic [7:0]    mem [DEPTH];
    state_t        state_reg, state_next;
    logic [AW-1:0] ptr_reg, ptr_next;
    logic [7:0]    remaining_reg, remaining_next;
    logic [31:0]   tdata_reg, tdata_next;
    logic          tvalid_reg, tvalid_next;
    logic [31:0]   fetch_word;

    // Memory is never reset; writes land in any state.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Each byte lane wraps independently, so a beat may straddle the top of memory.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign fetch_word[8*gi +: 8] = mem[ptr_reg + AW'(gi)];
        end
    endgenerate

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            remaining_reg <= '0;
            tdata_reg     <= '0;
            tvalid_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            remaining_reg <= remaining_next;
            tdata_reg     <= tdata_next;
            tvalid_reg    <= tvalid_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        remaining_next = remaining_reg;
        tdata_next     = tdata_reg;
        tvalid_next    = tvalid_reg;
        unique case (state_reg)
            IDLE: begin
                if (bus.req_valid) begin
                    ptr_next       = bus.req_addr;
                    remaining_next = bus.req_len;
                    state_next     = LOAD;
                end
            end
            LOAD: begin
                tdata_next  = fetch_word;
                tvalid_next = 1'b1;
                ptr_next    = ptr_reg + AW'(4);
                state_next  = SEND;
            end
            SEND: begin
                if (tvalid_reg && bus.m_axis_tready) begin
                    if (remaining_reg != 8'd0) begin
                        tdata_next     = fetch_word;
                        ptr_next       = ptr_reg + AW'(4);
                        remaining_next = remaining_reg - 8'd1;
                    end else begin
                        tvalid_next = 1'b0;
                        state_next  = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.req_ready     = (state_reg == IDLE);
    assign busy              = (state_reg != IDLE);
    assign bus.m_axis_tdata  = tdata_reg;
    assign bus.m_axis_tvalid = tvalid_reg;
`ifdef AXI_RAM_TLAST_EN
    // remaining only changes on a handshake, so this stays stable through stalls
    assign bus.m_axis_tlast  = tvalid_reg && (remaining_reg == 8'd0);
`endif
endmodule

// File: tb/tb_axi_ram_reader.sv
// Directed bench for axi_ram_reader: table of bursts plus wrap, long-burst, same-edge and reset sequences.
module tb_axi_ram_reader;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic          aclk = 1'b0;
    logic          areset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          busy;

    axi_ram_reader_if #(.AW(AW)) rif ();

    axi_ram_reader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .aclk    (aclk),
        .areset  (areset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .bus     (rif.master),
        .busy    (busy)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;
    logic [7:0] model_mem [DEPTH];

    typedef struct {
        logic [7:0]  addr;
        logic [7:0]  len;
        logic [3:0]  pat;      // tready schedule, bit (cycle % 4)
        logic [31:0] exp_first;
        logic [31:0] exp_last;
    } burst_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [7:0] a);
        logic [7:0] a1, a2, a3;
        a1 = a + 8'd1;
        a2 = a + 8'd2;
        a3 = a + 8'd3;
        return {model_mem[a3], model_mem[a2], model_mem[a1], model_mem[a]};
    endfunction

    task automatic wr_byte(input logic [7:0] a, input logic [7:0] d);
        @(negedge aclk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        model_mem[a] = d;
        @(posedge aclk);
        #1 wr_en = 1'b0;
    endtask

    task automatic run_burst(input string name, input logic [7:0] addr, input logic [7:0] len,
                             input logic [3:0] pat, input logic [31:0] exp_first,
                             input logic [31:0] exp_last);
        int beats, cyc, total, limit;
        logic held;
        logic [31:0] prev, first_w, last_w;
        logic [7:0] ba;
        beats = 0; cyc = 0; total = int'(len) + 1; limit = total * 4 + 8;
        held = 1'b0; prev = '0; first_w = '0; last_w = '0;
        @(negedge aclk);
        chk({name, " req_ready idle"}, 32'(rif.req_ready), 32'd1);
        rif.req_valid = 1'b1; rif.req_addr = addr; rif.req_len = len; rif.m_axis_tready = 1'b0;
        @(negedge aclk);
        rif.req_valid = 1'b0;
        chk({name, " tvalid in load"}, 32'(rif.m_axis_tvalid), 32'd0);
        chk({name, " busy in load"}, 32'(busy), 32'd1);
        @(negedge aclk);
        while (beats < total && cyc < limit) begin
            if (cyc > 0) @(negedge aclk);
            chk({name, " tvalid held high"}, 32'(rif.m_axis_tvalid), 32'd1);
            chk({name, " req_ready busy"}, 32'(rif.req_ready), 32'd0);
            if (held) chk({name, " stalled tdata stable"}, rif.m_axis_tdata, prev);
            rif.m_axis_tready = pat[cyc % 4];
            if (rif.m_axis_tvalid && rif.m_axis_tready) begin
                ba = addr + 8'(beats * 4);
                chk({name, " beat data"}, rif.m_axis_tdata, model_word(ba));
`ifdef AXI_RAM_TLAST_EN
                chk({name, " tlast"}, 32'(rif.m_axis_tlast), 32'(beats == int'(len)));
`endif
                if (beats == 0) first_w = rif.m_axis_tdata;
                last_w = rif.m_axis_tdata;
                $display("%s beat %0d addr 0x%02h data 0x%08h", name, beats, ba, rif.m_axis_tdata);
                beats++;
            end
            held = rif.m_axis_tvalid && !rif.m_axis_tready;
            prev = rif.m_axis_tdata;
            cyc++;
        end
        @(negedge aclk);
        rif.m_axis_tready = 1'b0;
        chk({name, " beat count"}, 32'(beats), 32'(total));
        chk({name, " tvalid after burst"}, 32'(rif.m_axis_tvalid), 32'd0);
        chk({name, " req_ready after burst"}, 32'(rif.req_ready), 32'd1);
        chk({name, " busy after burst"}, 32'(busy), 32'd0);
        chk({name, " first word"}, first_w, exp_first);
        chk({name, " last word"}, last_w, exp_last);
    endtask

    burst_vec_t vecs [7];

    initial begin
        vecs[0] = '{8'h00, 8'd3, 4'b1111, 32'h03020100, 32'h0F0E0D0C};
        vecs[1] = '{8'h00, 8'd3, 4'b1001, 32'h03020100, 32'h0F0E0D0C};
        vecs[2] = '{8'h10, 8'd1, 4'b0101, 32'h13121110, 32'h17161514};
        vecs[3] = '{8'hFA, 8'd2, 4'b1111, 32'hFDFCFBFA, 32'h05040302};
        vecs[4] = '{8'hFE, 8'd0, 4'b1111, 32'h0100FFFE, 32'h0100FFFE};
        vecs[5] = '{8'h81, 8'd0, 4'b0011, 32'h84838281, 32'h84838281};
        vecs[6] = '{8'h20, 8'd2, 4'b0110, 32'h23222120, 32'h2B2A2928};

        areset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rif.req_valid = 1'b0; rif.req_addr = '0; rif.req_len = '0; rif.m_axis_tready = 1'b0;
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        chk("reset tvalid", 32'(rif.m_axis_tvalid), 32'd0);
        chk("reset tdata", rif.m_axis_tdata, 32'd0);
        chk("reset req_ready", 32'(rif.req_ready), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
`ifdef AXI_RAM_TLAST_EN
        chk("reset tlast", 32'(rif.m_axis_tlast), 32'd0);
`endif

        for (int i = 0; i < DEPTH; i++) wr_byte(8'(i), 8'(i));

        for (int i = 0; i < 7; i++) begin
            run_burst($sformatf("vec%0d", i), vecs[i].addr, vecs[i].len, vecs[i].pat,
                      vecs[i].exp_first, vecs[i].exp_last);
        end

        // single beat straddling the top of memory
        wr_byte(8'd254, 8'hAA); wr_byte(8'd255, 8'hBB);
        wr_byte(8'd0, 8'hCC);   wr_byte(8'd1, 8'hDD);
        run_burst("wrap", 8'd254, 8'd0, 4'b1111, 32'hDDCCBBAA, 32'hDDCCBBAA);

        // 256 beats, memory wraps four times
        run_burst("long", 8'd0, 8'd255, 4'b1111, 32'h0302DDCC, 32'hBBAAFDFC);

        // write and fetch of the same byte on the LOAD edge returns the old byte
        @(negedge aclk);
        rif.req_valid = 1'b1; rif.req_addr = 8'h40; rif.req_len = 8'd0;
        @(negedge aclk);
        rif.req_valid = 1'b0;
        wr_en = 1'b1; wr_addr = 8'h40; wr_data = 8'h99;
        @(negedge aclk);
        wr_en = 1'b0;
        chk("same-edge old byte", rif.m_axis_tdata, 32'h43424140);
        chk("same-edge tvalid", 32'(rif.m_axis_tvalid), 32'd1);
        model_mem[8'h40] = 8'h99;
        rif.m_axis_tready = 1'b1;
        @(negedge aclk);
        rif.m_axis_tready = 1'b0;
        chk("same-edge done", 32'(rif.m_axis_tvalid), 32'd0);
        $display("same-edge read 0x40 returned old byte");
        run_burst("after-write", 8'h40, 8'd0, 4'b1111, 32'h43424199, 32'h43424199);

        // reset mid-burst, while beat 3 is being offered
        @(negedge aclk);
        rif.req_valid = 1'b1; rif.req_addr = 8'h00; rif.req_len = 8'd3; rif.m_axis_tready = 1'b1;
        @(negedge aclk);
        rif.req_valid = 1'b0;
        @(negedge aclk);
        chk("pre-reset beat1", rif.m_axis_tdata, 32'h0302DDCC);
        @(negedge aclk);
        chk("pre-reset beat2", rif.m_axis_tdata, 32'h07060504);
        @(negedge aclk);
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        chk("mid-reset tvalid", 32'(rif.m_axis_tvalid), 32'd0);
        chk("mid-reset req_ready", 32'(rif.req_ready), 32'd1);
        chk("mid-reset busy", 32'(busy), 32'd0);
        chk("mid-reset tdata", rif.m_axis_tdata, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            chk("no beats after reset", 32'(rif.m_axis_tvalid), 32'd0);
        end
        rif.m_axis_tready = 1'b0;
        $display("reset mid-burst abandoned burst");
        run_burst("post-reset", 8'd0, 8'd3, 4'b1111, 32'h0302DDCC, 32'h0F0E0D0C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
